// File: rtl/fifo.sv
// Single-clock show-ahead FIFO of 32-bit words. Occupancy is implied by
// wrap-bit pointers. The head entry drives read_data_o combinationally.
module fifo #(
  parameter int ENTRIES_POW2 = 3
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] write_data_i,
  input  logic        write_i,
  input  logic        read_i,
  output logic        full_o,
  output logic        empty_o,
  output logic [31:0] read_data_o
);
  localparam int DEPTH = 1 << ENTRIES_POW2;
  localparam int AW    = ENTRIES_POW2;

  logic [AW:0]             wr_ptr_q, wr_ptr_d;
  logic [AW:0]             rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0][31:0]  mem_q, mem_d;
  logic                    rd_en, wr_en;

  // Equal pointers mean empty; equal index with differing wrap bits means full.
  assign empty_o     = (wr_ptr_q == rd_ptr_q);
  assign full_o      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                       (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign read_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // A pop in the same cycle frees a slot, so a write to a full FIFO is accepted.
  always_comb begin
    rd_en    = read_i && !empty_o;
    wr_en    = write_i && (!full_o || rd_en);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_en) begin
      mem_d[wr_ptr_q[AW-1:0]] = write_data_i;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end
endmodule

// File: tb/tb_fifo.sv
// Randomized and directed bench for fifo. A queue-based occupancy model
// predicts the flags and the head word.
module tb_fifo;
  localparam int CAP = 8;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic [31:0] write_data_i = '0;
  logic        write_i = 1'b0;
  logic        read_i = 1'b0;
  logic        full_o, empty_o;
  logic [31:0] read_data_o;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] q[$];

  fifo #(.ENTRIES_POW2(3)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .write_data_i(write_data_i),
    .write_i(write_i), .read_i(read_i), .full_o(full_o),
    .empty_o(empty_o), .read_data_o(read_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic chk_state(input string tag);
    chk({tag, " empty"}, {31'd0, empty_o}, {31'd0, q.size() == 0});
    chk({tag, " full"},  {31'd0, full_o},  {31'd0, q.size() == CAP});
    if (q.size() > 0) chk({tag, " head"}, read_data_o, q[0]);
  endtask

  // One clock: drive inputs, clock, advance the model, check.
  task automatic step(input logic w, input logic [31:0] d, input logic r, input string tag);
    bit rd, wr;
    write_i = w; write_data_i = d; read_i = r;
    @(posedge clk_i); #1;
    write_i = 1'b0; read_i = 1'b0;
    rd = r && q.size() > 0;
    wr = w && (q.size() < CAP || rd);
    if (rd) void'(q.pop_front());
    if (wr) q.push_back(d);
    chk_state(tag);
  endtask

  task automatic do_reset();
    reset_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    q.delete();
    chk("rst empty", {31'd0, empty_o}, 32'd1);
    chk("rst full",  {31'd0, full_o},  32'd0);
    chk("rst data",  read_data_o, 32'd0);
    reset_i = 1'b1;
  endtask

  initial begin
    // Scenario 1: double reset, read when empty
    do_reset();
    do_reset();
    step(1'b0, 32'd0, 1'b1, "s1 read empty");
    chk("s1 data", read_data_o, 32'd0);

    // Scenario 2: fill 1..8, 9 dropped
    for (int i = 1; i <= 7; i++) begin
      step(1'b1, i, 1'b0, "s2 fill");
      chk("s2 head1", read_data_o, 32'd1);
    end
    step(1'b1, 32'd8, 1'b0, "s2 eighth");
    chk("s2 full", {31'd0, full_o}, 32'd1);
    step(1'b1, 32'd9, 1'b0, "s2 drop");

    // Scenario 3: drain 1..8, extra read ignored
    for (int i = 1; i <= 8; i++) begin
      chk("s3 head", read_data_o, i);
      step(1'b0, 32'd0, 1'b1, "s3 drain");
    end
    chk("s3 empty", {31'd0, empty_o}, 32'd1);
    step(1'b0, 32'd0, 1'b1, "s3 extra");

    // Scenario 4: read+write mid-occupancy
    for (int i = 1; i <= 3; i++) step(1'b1, i, 1'b0, "s4 fill");
    step(1'b1, 32'd4, 1'b1, "s4 rw");
    chk("s4 head2", read_data_o, 32'd2);
    step(1'b1, 32'd5, 1'b0, "s4 w5");
    for (int i = 2; i <= 5; i++) begin
      chk("s4 head", read_data_o, i);
      step(1'b0, 32'd0, 1'b1, "s4 drain");
    end
    chk("s4 empty", {31'd0, empty_o}, 32'd1);

    // Read+write when empty: write only, no bypass
    step(1'b1, 32'd77, 1'b1, "rw empty");
    step(1'b0, 32'd0, 1'b1, "rw empty pop");

    // Scenario 5: read+write while full
    for (int i = 10; i < 18; i++) step(1'b1, i, 1'b0, "s5 fill");
    step(1'b1, 32'd99, 1'b1, "s5 rw");
    chk("s5 full", {31'd0, full_o}, 32'd1);
    chk("s5 head", read_data_o, 32'd11);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("s5 last", read_data_o, 32'd99);
      step(1'b0, 32'd0, 1'b1, "s5 drain");
    end

    // Scenario 6: asynchronous reset mid-fill
    for (int i = 0; i < 5; i++) step(1'b1, 32'hA0 + i, 1'b0, "s6 fill");
    #3 reset_i = 1'b0;
    #1;
    q.delete();
    chk("s6 async empty", {31'd0, empty_o}, 32'd1);
    chk("s6 async full",  {31'd0, full_o},  32'd0);
    chk("s6 async data",  read_data_o, 32'd0);
    @(posedge clk_i); #1;
    chk("s6 held data", read_data_o, 32'd0);
    reset_i = 1'b1;

    // Random traffic with biased fill/drain phases
    for (int i = 0; i < 600; i++) begin
      int wp;
      wp = ((i / 60) % 2 == 0) ? 75 : 25;
      step($urandom_range(0, 99) < wp, $urandom, $urandom_range(0, 99) < (100 - wp), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
